mips_boot_loader: RTL and testbench

//   Upstream of the single-cycle mips core: fills instruction memory from a byte-serial

---
 rtl/mips_boot_loader_if.sv | 27 ++
 rtl/mips_boot_loader.sv | 111 +++++++++++
 tb/tb_mips_boot_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_boot_loader_if.sv
// Byte-stream input and instruction-memory/core-control outputs of the boot loader.
// The master side is the image source plus the memory/core; the slave side is the loader.
interface mips_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_last;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    modport master (
        output in_valid, in_byte, in_last,
        input  in_ready, im_we, im_addr, im_wdata, cpu_reset, done, error, word_count
    );

    modport slave (
        input  in_valid, in_byte, in_last,
        output in_ready, im_we, im_addr, im_wdata, cpu_reset, done, error, word_count
    );
endinterface

// File: rtl/mips_boot_loader.sv
// Loads a big-endian byte stream into instruction memory while holding the mips core
// in reset, then releases the core after a fixed hold time.
module mips_boot_loader #(
    parameter int ADDR_W     = 10,
    parameter int RESET_HOLD = 4
) (
    input  logic              clock,
    input  logic              reset,
    mips_boot_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_INIT, S_LOAD, S_WRITE, S_RELEASE, S_RUN, S_ERR
    } state_t;

    localparam int              HOLD_W   = $clog2(RESET_HOLD + 1);
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic [1:0]        r_k;
    logic [23:0]       r_partial;
    logic              r_last;
    logic [HOLD_W-1:0] r_hold;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W:0]   r_count;

    logic w_xfer;

    assign w_xfer        = bus.in_valid && (r_state == S_LOAD);
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.im_we     = r_we;
    assign bus.im_addr   = r_addr;
    assign bus.im_wdata  = r_wdata;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.word_count = r_count;

    // Leading bytes of the current word; the 4th byte goes straight into r_wdata.
    always_ff @(posedge clock) begin
        if (w_xfer && (r_k != 2'd3)) begin
            r_partial <= {r_partial[15:0], bus.in_byte};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_k         <= 2'd0;
            r_last      <= 1'b0;
            r_hold      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_INIT: r_state <= S_LOAD;
                S_LOAD: begin
                    if (w_xfer) begin
                        if (r_k != 2'd3) begin
                            if (bus.in_last) begin
                                r_state <= S_ERR;
                                r_error <= 1'b1;
                            end else begin
                                r_k <= r_k + 2'd1;
                            end
                        end else if (r_count == CAPACITY) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_wdata <= {r_partial, bus.in_byte};
                            r_last  <= bus.in_last;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_count <= r_count + 1'b1;
                    r_k     <= 2'd0;
                    if (r_last) begin
                        r_state <= S_RELEASE;
                        r_hold  <= HOLD_W'(RESET_HOLD - 1);
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_RELEASE: begin
                    if (r_hold == '0) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized scoreboard bench for mips_boot_loader against a byte-stream reference model.
module tb_mips_boot_loader;
    localparam int AW   = 2;
    localparam int HOLD = 4;
    localparam int CAP  = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mips_boot_loader_if #(.ADDR_W(AW)) bus();

    mips_boot_loader #(.ADDR_W(AW), .RESET_HOLD(HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] s_byte[$];
    bit         s_last[$];
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && bus.im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_im_we", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("im_addr", 64'(bus.im_addr), 64'(mon_e.addr));
                chk("im_wdata", 64'(bus.im_wdata), 64'(mon_e.data));
            end
        end
    end

    // Reference model: scans the stream, returns bytes to send, expected word count and error.
    task automatic model(output int n_send, output int exp_cnt, output bit exp_err);
        wr_t w;
        exp_cnt = 0;
        exp_err = 1'b0;
        n_send  = s_byte.size();
        for (int i = 0; i < s_byte.size(); i++) begin
            if (i % 4 == 3) begin
                if (exp_cnt == CAP) begin
                    exp_err = 1'b1;
                    n_send  = i + 1;
                    return;
                end
                w.addr = exp_cnt;
                w.data = {s_byte[i-3], s_byte[i-2], s_byte[i-1], s_byte[i]};
                exp_q.push_back(w);
                exp_cnt++;
                if (s_last[i]) begin
                    n_send = i + 1;
                    return;
                end
            end else if (s_last[i]) begin
                exp_err = 1'b1;
                n_send  = i + 1;
                return;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit last, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.in_last  = last;
        t = 0;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            t++;
            if (t > 40) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic apply_reset();
        #1;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        s_byte.delete();
        s_last.delete();
        exp_q.delete();
        @(negedge clock);
        chk("rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_im_we", 64'(bus.im_we), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_word_count", 64'(bus.word_count), 64'd0);
        chk("rst_im_addr", 64'(bus.im_addr), 64'd0);
        chk("rst_im_wdata", 64'(bus.im_wdata), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit last);
        s_byte.push_back(b);
        s_last.push_back(last);
    endtask

    task automatic run_image(input bit gaps);
        int n, cnt, t, hold;
        bit err;
        model(n, cnt, err);
        for (int i = 0; i < n; i++) send(s_byte[i], s_last[i], gaps);
        if (err) begin
            chk("err_error", 64'(bus.error), 64'd1);
            chk("err_in_ready", 64'(bus.in_ready), 64'd0);
            chk("err_cpu_reset", 64'(bus.cpu_reset), 64'd1);
            repeat (3) @(negedge clock);
            chk("err_sticky", 64'(bus.error), 64'd1);
            chk("err_done", 64'(bus.done), 64'd0);
        end else begin
            t = 0;
            @(negedge clock);
            while (!bus.im_we && t < 8) begin
                t++;
                @(negedge clock);
            end
            chk("last_im_we_seen", 64'(bus.im_we), 64'd1);
            hold = 0;
            @(negedge clock);
            while (bus.cpu_reset && hold < 20) begin
                hold++;
                @(negedge clock);
            end
            chk("cpu_reset_hold", 64'(hold), 64'(HOLD));
            chk("run_done", 64'(bus.done), 64'd1);
            chk("run_cpu_reset", 64'(bus.cpu_reset), 64'd0);
            chk("run_in_ready", 64'(bus.in_ready), 64'd0);
            chk("run_error", 64'(bus.error), 64'd0);
        end
        chk("word_count", 64'(bus.word_count), 64'(cnt));
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push_sample();
        push_byte(8'h20, 0); push_byte(8'h08, 0); push_byte(8'h00, 0); push_byte(8'h05, 0);
        push_byte(8'h8C, 0); push_byte(8'h09, 0); push_byte(8'h00, 0); push_byte(8'h00, 1);
    endtask

    initial begin
        int nw, total;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        bus.in_last  = 1'b0;

        // Two-word program, back-to-back bytes.
        apply_reset();
        push_sample();
        run_image(1'b0);
        chk("t1_count_is_2", 64'(bus.word_count), 64'd2);

        // Input after done is ignored.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_byte = 8'($urandom);
            bus.in_last = (i == 7);
            @(negedge clock);
            chk("run_ignore_ready", 64'(bus.in_ready), 64'd0);
            chk("run_ignore_we", 64'(bus.im_we), 64'd0);
            chk("run_ignore_cpu_reset", 64'(bus.cpu_reset), 64'd0);
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("run_ignore_count", 64'(bus.word_count), 64'd2);

        // Same program with random valid gaps.
        apply_reset();
        push_sample();
        run_image(1'b1);

        // Truncated word.
        apply_reset();
        push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 1);
        run_image(1'b0);

        // Overflow: one word more than capacity.
        apply_reset();
        for (int i = 0; i < 4 * (CAP + 1); i++) push_byte(8'($urandom), i == 4 * (CAP + 1) - 1);
        run_image(1'b1);
        chk("ovf_count_is_cap", 64'(bus.word_count), 64'(CAP));

        // Reset in the middle of a word, then a single-word image.
        apply_reset();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        chk("async_in_ready", 64'(bus.in_ready), 64'd0);
        apply_reset();
        push_byte(8'hDE, 0); push_byte(8'hAD, 0); push_byte(8'hBE, 0); push_byte(8'hEF, 1);
        run_image(1'b0);

        // Random images, some truncated, some overflowing.
        for (int r = 0; r < 8; r++) begin
            apply_reset();
            nw = $urandom_range(1, CAP + 1);
            total = 4 * nw;
            if ($urandom_range(0, 3) == 0) total = 4 * (nw - 1) + $urandom_range(1, 3);
            for (int i = 0; i < total; i++) push_byte(8'($urandom), i == total - 1);
            run_image(1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
